mul_share_ctrl: RTL and testbench

Sequencer and arbiter that shares one external 4x4 array multiplier between two requesters.
- Round-robin grant, valid/ready handshakes on request and response sides.
- Waits out a configurable multiplier latency, then captures the product.
- Optional per-requester multiply-accumulate into a wrapping accumulator.
- Sits between the top-level pin mux and the combinational array multiplier datapath.

---
 rtl/mul_share_ctrl.sv | 96 +++++++++
 tb/tb_mul_share_ctrl.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/mul_share_ctrl.sv
// mul_share_ctrl: round-robin sequencer sharing one external 4x4 multiplier between two requesters
module mul_share_ctrl #(
    parameter int MUL_LAT = 0,
    parameter int ACC_W   = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [3:0]       req0_a,
    input  logic [3:0]       req0_b,
    input  logic             req0_op,
    input  logic             req0_acc_clr,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [3:0]       req1_a,
    input  logic [3:0]       req1_b,
    input  logic             req1_op,
    input  logic             req1_acc_clr,
    output logic [3:0]       mul_m,
    output logic [3:0]       mul_q,
    input  logic [7:0]       mul_p,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [ACC_W-1:0] res_data,
    output logic             res_id,
    output logic             busy
);
    localparam int CW = (MUL_LAT > 0) ? $clog2(MUL_LAT + 1) : 1;
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
    state_t           state;
    logic             last_grant, grant, id_r, op_r, cap;
    logic [CW-1:0]    cnt;
    logic [ACC_W-1:0] acc0, acc1, p_ext, acc_base, acc_new;
    // arbitration, capture timing and the accumulate path (a clear in the capture cycle zeroes the base)
    always_comb begin
        grant      = (req0_valid && req1_valid) ? !last_grant : req1_valid;
        req0_ready = (state == IDLE) && req0_valid && !grant;
        req1_ready = (state == IDLE) && req1_valid && grant;
        cap        = (state == EXEC) && (cnt == CW'(MUL_LAT));
        p_ext      = ACC_W'(mul_p);
        acc_base   = id_r ? (req1_acc_clr ? '0 : acc1) : (req0_acc_clr ? '0 : acc0);
        acc_new    = acc_base + p_ext;
    end
    // sequencer: accept one op, hold operands until the product is due, then present the result
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            id_r       <= 1'b0;
            op_r       <= 1'b0;
            cnt        <= '0;
            acc0       <= '0;
            acc1       <= '0;
            mul_m      <= '0;
            mul_q      <= '0;
            res_valid  <= 1'b0;
            res_data   <= '0;
            res_id     <= 1'b0;
            busy       <= 1'b0;
        end else begin
            if (req0_acc_clr) acc0 <= '0;
            if (req1_acc_clr) acc1 <= '0;
            case (state)
                IDLE: if (req0_ready || req1_ready) begin
                    id_r       <= grant;
                    last_grant <= grant;
                    op_r       <= grant ? req1_op : req0_op;
                    mul_m      <= grant ? req1_a : req0_a;
                    mul_q      <= grant ? req1_b : req0_b;
                    cnt        <= '0;
                    busy       <= 1'b1;
                    state      <= EXEC;
                end
                EXEC: if (cap) begin
                    mul_m     <= '0;
                    mul_q     <= '0;
                    res_valid <= 1'b1;
                    res_id    <= id_r;
                    res_data  <= op_r ? acc_new : p_ext;
                    if (op_r && !id_r) acc0 <= acc_new;
                    if (op_r && id_r) acc1 <= acc_new;
                    state     <= RESP;
                end else begin
                    cnt <= cnt + CW'(1);
                end
                RESP: if (res_ready) begin
                    res_valid <= 1'b0;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mul_share_ctrl.sv
// tb_mul_share_ctrl: table, directed and randomized checks of the shared multiplier sequencer
module tb_mul_share_ctrl;
    logic        clk = 0, rst = 1;
    logic        req0_valid = 0, req0_op = 0, req0_acc_clr = 0, req0_ready;
    logic        req1_valid = 0, req1_op = 0, req1_acc_clr = 0, req1_ready;
    logic [3:0]  req0_a = 0, req0_b = 0, req1_a = 0, req1_b = 0, mul_m, mul_q;
    logic [7:0]  mul_p;
    logic        res_valid, res_ready = 0, res_id, busy;
    logic [11:0] res_data;
    logic        d2_v = 0, d2_rdy, d2_rdy1, d2_rr = 0, d2_rv, d2_id, d2_busy;
    logic [3:0]  d2_a = 0, d2_b = 0, d2_m, d2_q;
    logic [7:0]  d2_p;
    logic [11:0] d2_rd;
    int          vec = 0, errs = 0;

    always #5 clk = ~clk;
    assign mul_p = {4'd0, mul_m} * {4'd0, mul_q};
    assign d2_p  = {4'd0, d2_m} * {4'd0, d2_q};

    mul_share_ctrl #(.MUL_LAT(0), .ACC_W(12)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
        .req0_op(req0_op), .req0_acc_clr(req0_acc_clr),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
        .req1_op(req1_op), .req1_acc_clr(req1_acc_clr),
        .mul_m(mul_m), .mul_q(mul_q), .mul_p(mul_p),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_id(res_id), .busy(busy)
    );

    mul_share_ctrl #(.MUL_LAT(2), .ACC_W(12)) d2 (
        .clk(clk), .rst(rst),
        .req0_valid(d2_v), .req0_ready(d2_rdy), .req0_a(d2_a), .req0_b(d2_b),
        .req0_op(1'b0), .req0_acc_clr(1'b0),
        .req1_valid(1'b0), .req1_ready(d2_rdy1), .req1_a(4'd0), .req1_b(4'd0),
        .req1_op(1'b0), .req1_acc_clr(1'b0),
        .mul_m(d2_m), .mul_q(d2_q), .mul_p(d2_p),
        .res_valid(d2_rv), .res_ready(d2_rr), .res_data(d2_rd), .res_id(d2_id), .busy(d2_busy)
    );

    typedef struct {
        logic v0; logic [3:0] a0, b0; logic o0;
        logic v1; logic [3:0] a1, b1; logic o1;
        int hold; logic eg; logic [11:0] ed;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vec++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        rst = 1;
        req0_valid = 0; req1_valid = 0; req0_acc_clr = 0; req1_acc_clr = 0; res_ready = 0;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 0;
        chk("rst_ready0", req0_ready, 0);
        chk("rst_ready1", req1_ready, 0);
        chk("rst_mul_m", mul_m, 0);
        chk("rst_mul_q", mul_q, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_res_data", res_data, 0);
        chk("rst_res_id", res_id, 0);
        chk("rst_busy", busy, 0);
    endtask

    // one complete transaction on the MUL_LAT=0 instance; the losing requester stays valid
    task automatic txn(input logic v0, input logic [3:0] a0, input logic [3:0] b0, input logic o0, input logic c0,
                       input logic v1, input logic [3:0] a1, input logic [3:0] b1, input logic o1, input logic c1,
                       input int hold, input logic eg, input logic [11:0] ed);
        req0_valid = v0; req0_a = a0; req0_b = b0; req0_op = o0; req0_acc_clr = c0;
        req1_valid = v1; req1_a = a1; req1_b = b1; req1_op = o1; req1_acc_clr = c1;
        #1;
        chk("grant_ready0", req0_ready, !eg);
        chk("grant_ready1", req1_ready, eg);
        @(posedge clk);
        #1;
        if (eg) req1_valid = 0; else req0_valid = 0;
        chk("exec_busy", busy, 1);
        chk("exec_mul_m", mul_m, eg ? a1 : a0);
        chk("exec_mul_q", mul_q, eg ? b1 : b0);
        chk("exec_res_valid", res_valid, 0);
        @(posedge clk);
        #1;
        chk("resp_valid", res_valid, 1);
        chk("resp_data", res_data, ed);
        chk("resp_id", res_id, eg);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            chk("hold_valid", res_valid, 1);
            chk("hold_data", res_data, ed);
            chk("hold_id", res_id, eg);
            chk("hold_ready0", req0_ready, 0);
            chk("hold_ready1", req1_ready, 0);
            chk("hold_mul_m", mul_m, 0);
        end
        res_ready = 1;
        @(posedge clk);
        #1 res_ready = 0;
        chk("done_valid", res_valid, 0);
        chk("done_busy", busy, 0);
    endtask

    vec_t        tbl[7];
    logic        pend[2], ro[2], last_m, g, c0, c1, cg;
    logic [3:0]  ra[2], rb[2];
    logic [11:0] acc_m[2], p, res;

    initial begin
        tbl[0] = '{1, 3, 5, 0, 1, 15, 15, 0, 5, 0, 15};
        tbl[1] = '{0, 3, 5, 0, 1, 15, 15, 0, 0, 1, 225};
        tbl[2] = '{1, 3, 5, 0, 1, 15, 15, 0, 0, 0, 15};
        tbl[3] = '{0, 3, 5, 0, 1, 15, 15, 0, 0, 1, 225};
        tbl[4] = '{1, 7, 9, 0, 0, 0, 0, 0, 0, 0, 63};
        tbl[5] = '{1, 2, 2, 0, 1, 4, 5, 0, 1, 1, 20};
        tbl[6] = '{1, 2, 2, 0, 0, 4, 5, 0, 0, 0, 4};
        do_reset();
        // MUL_LAT=2 instance: operands held three cycles, result one cycle later
        d2_v = 1; d2_a = 4; d2_b = 4;
        #1 chk("d2_ready", d2_rdy, 1);
        @(posedge clk);
        #1 d2_v = 0;
        for (int i = 0; i < 3; i++) begin
            chk("d2_mul_m", d2_m, 4);
            chk("d2_mul_q", d2_q, 4);
            chk("d2_res_valid_early", d2_rv, 0);
            @(posedge clk);
            #1;
        end
        chk("d2_res_valid", d2_rv, 1);
        chk("d2_res_data", d2_rd, 16);
        chk("d2_mul_m_idle", d2_m, 0);
        d2_rr = 1;
        @(posedge clk);
        #1 d2_rr = 0;
        chk("d2_done", d2_rv, 0);
        // arbitration and result table
        for (int k = 0; k < 7; k++)
            txn(tbl[k].v0, tbl[k].a0, tbl[k].b0, tbl[k].o0, 1'b0,
                tbl[k].v1, tbl[k].a1, tbl[k].b1, tbl[k].o1, 1'b0,
                tbl[k].hold, tbl[k].eg, tbl[k].ed);
        // accumulator wrap, then a clear coinciding with the capture
        for (int k = 1; k <= 19; k++)
            txn(0, 0, 0, 0, 0, 1, 15, 15, 1, 0, 0, 1, 12'(225 * k));
        txn(0, 0, 0, 0, 0, 1, 15, 15, 1, 1, 0, 1, 225);
        req1_acc_clr = 0;
        // asynchronous reset in the middle of an operation
        do_reset();
        txn(1, 5, 10, 1, 0, 0, 0, 0, 0, 0, 0, 0, 50);
        req0_valid = 1; req0_a = 3; req0_b = 3; req0_op = 1;
        @(posedge clk);
        #1 req0_valid = 0;
        chk("mid_busy", busy, 1);
        #2 rst = 1;
        #1;
        chk("async_busy", busy, 0);
        chk("async_mul_m", mul_m, 0);
        chk("async_res_valid", res_valid, 0);
        @(posedge clk);
        #1 rst = 0;
        @(posedge clk);
        #1 chk("dropped_res_valid", res_valid, 0);
        txn(1, 2, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0, 6);
        // randomized traffic against a transaction-level model
        do_reset();
        acc_m[0] = 0; acc_m[1] = 0; last_m = 1; pend[0] = 0; pend[1] = 0;
        for (int k = 0; k < 150; k++) begin
            for (int n = 0; n < 2; n++)
                if (!pend[n] && $urandom_range(0, 2) != 0) begin
                    pend[n] = 1; ra[n] = 4'($urandom); rb[n] = 4'($urandom); ro[n] = 1'($urandom);
                end
            if (!pend[0] && !pend[1]) begin
                pend[0] = 1; ra[0] = 4'($urandom); rb[0] = 4'($urandom); ro[0] = 1'($urandom);
            end
            c0 = ($urandom_range(0, 7) == 0);
            c1 = ($urandom_range(0, 7) == 0);
            g = (pend[0] && pend[1]) ? !last_m : pend[1];
            cg = g ? c1 : c0;
            p = 12'(ra[g]) * 12'(rb[g]);
            res = ro[g] ? (cg ? 12'd0 : acc_m[g]) + p : p;
            txn(pend[0], ra[0], rb[0], ro[0], c0, pend[1], ra[1], rb[1], ro[1], c1,
                $urandom_range(0, 2), g, res);
            if (ro[g]) acc_m[g] = res;
            if (c0) acc_m[0] = 0;
            if (c1) acc_m[1] = 0;
            last_m = g;
            pend[g] = 0;
        end
        req0_valid = 0; req1_valid = 0; req0_acc_clr = 0; req1_acc_clr = 0;
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end
endmodule
